// File: rtl/post_code_logger.sv
// POST-code logger: queues port-0x80 writes in a FIFO and replays each one as "HH\r\n" on an 8N1 UART TX pin.
// Optional feature (macro POST_DEDUP_EN): a code equal to the last accepted code is discarded.
module post_code_logger #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BAUD_DIV   = 286
) (
    input  logic                lclk,
    input  logic                lreset_n,
    input  logic                post_wr,
    input  logic [7:0]          post_data,
    output logic                tx,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                overflow,
    output logic                busy
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int BW    = $clog2(BAUD_DIV);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [BW-1:0]         BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]         BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CR   = 3'd4,
        S_LF   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_tx;
    logic                  r_busy;
    logic [7:0]            r_code;
    logic [3:0]            r_bit_cnt;
    logic [BW-1:0]         r_baud_cnt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_dup;
    logic                  w_sending;
    logic                  w_char_done;
    logic                  w_tx_nxt;
    logic [7:0]            w_char;
    logic [9:0]            w_frame;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

`ifdef POST_DEDUP_EN
    logic [7:0] r_last;
    logic       r_last_vld;

    assign w_dup = r_last_vld && (post_data == r_last);

    // Remember the most recently accepted code for duplicate suppression
    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            r_last     <= 8'h00;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= post_data;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign w_pop  = (r_state == S_POP) && (r_count != CNT_ZERO);
    assign w_push = post_wr && !w_dup && ((r_count != CNT_FULL) || w_pop);
    assign w_drop = post_wr && !w_dup && (r_count == CNT_FULL) && !w_pop;

    // FIFO storage write port
    always_ff @(posedge lclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= post_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            r_wptr     <= {DEPTH_LOG2{1'b0}};
            r_rptr     <= {DEPTH_LOG2{1'b0}};
            r_count    <= CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Character currently being serialised for the active state
    always_comb begin
        w_char = 8'h0A;
        case (r_state)
            S_HI:    w_char = hex_ascii(r_code[7:4]);
            S_LO:    w_char = hex_ascii(r_code[3:0]);
            S_CR:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    assign w_frame     = {1'b1, w_char, 1'b0};
    assign w_sending   = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CR) || (r_state == S_LF);
    assign w_char_done = (r_bit_cnt == 4'd9) && (r_baud_cnt == BAUD_LAST);

    // Sender next-state and next TX bit
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != CNT_ZERO) begin
                    w_state_nxt = S_POP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_POP: begin
                if (w_pop) begin
                    w_state_nxt = S_HI;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HI: begin
                w_tx_nxt = w_frame[r_bit_cnt];
                if (w_char_done) begin
                    w_state_nxt = S_LO;
                end else begin
                    w_state_nxt = S_HI;
                end
            end
            S_LO: begin
                w_tx_nxt = w_frame[r_bit_cnt];
                if (w_char_done) begin
                    w_state_nxt = S_CR;
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            S_CR: begin
                w_tx_nxt = w_frame[r_bit_cnt];
                if (w_char_done) begin
                    w_state_nxt = S_LF;
                end else begin
                    w_state_nxt = S_CR;
                end
            end
            S_LF: begin
                w_tx_nxt = w_frame[r_bit_cnt];
                if (w_char_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LF;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Sender state register
    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Baud and bit counters; they restart for every character so characters abut exactly
    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            r_baud_cnt <= {BW{1'b0}};
            r_bit_cnt  <= 4'd0;
        end else if (w_sending) begin
            if (r_baud_cnt == BAUD_LAST) begin
                r_baud_cnt <= {BW{1'b0}};
                if (r_bit_cnt == 4'd9) begin
                    r_bit_cnt <= 4'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_ONE;
            end
        end else begin
            r_baud_cnt <= {BW{1'b0}};
            r_bit_cnt  <= 4'd0;
        end
    end

    // Code latch, registered TX line and busy flag
    always_ff @(posedge lclk or negedge lreset_n) begin
        if (!lreset_n) begin
            r_code <= 8'h00;
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            if (w_pop) begin
                r_code <= r_mem[r_rptr];
            end
            r_tx   <= w_tx_nxt;
            r_busy <= (r_count != CNT_ZERO) || (r_state != S_IDLE);
        end
    end

    assign tx         = r_tx;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_post_code_logger.sv
// Directed bench for post_code_logger: a default-rate instance for exact line timing and a
// fast-baud instance (same stimulus) for the multi-line FIFO scenarios.
module tb_post_code_logger;
    localparam int SLOW_BAUD = 286;
    localparam int FAST_BAUD = 4;

    logic       lclk      = 1'b0;
    logic       lreset_n  = 1'b0;
    logic       post_wr   = 1'b0;
    logic [7:0] post_data = 8'h00;
    logic       tx_s, tx_f, ovf_s, ovf_f, busy_s, busy_f;
    logic [4:0] cnt_s, cnt_f;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    post_code_logger u_dut_slow (
        .lclk(lclk), .lreset_n(lreset_n), .post_wr(post_wr), .post_data(post_data),
        .tx(tx_s), .fifo_count(cnt_s), .overflow(ovf_s), .busy(busy_s)
    );

    post_code_logger #(.BAUD_DIV(FAST_BAUD)) u_dut_fast (
        .lclk(lclk), .lreset_n(lreset_n), .post_wr(post_wr), .post_data(post_data),
        .tx(tx_f), .fifo_count(cnt_f), .overflow(ovf_f), .busy(busy_f)
    );

    always #15 lclk = ~lclk;

    always @(posedge lclk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_line(input logic [7:0] v);
        string t;
        t = "0123456789ABCDEF";
        return {t.getc(int'(v[7:4])), t.getc(int'(v[3:0])), 8'h0D, 8'h0A};
    endfunction

    task automatic apply_reset();
        post_wr  = 1'b0;
        lreset_n = 1'b0;
        repeat (3) @(negedge lclk);
        lreset_n = 1'b1;
        @(negedge lclk);
    endtask

    // Receives one 8N1 character; ok is 0 on timeout or a bad stop bit.
    task automatic get_char(input bit slow, output logic [7:0] c, output bit ok);
        int baud;
        int n;
        baud = slow ? SLOW_BAUD : FAST_BAUD;
        n = 0;
        ok = 1'b0;
        c = 8'h00;
        while (((slow ? tx_s : tx_f) !== 1'b0) && (n < 40 * baud)) begin
            @(negedge lclk);
            n++;
        end
        if ((slow ? tx_s : tx_f) === 1'b0) begin
            repeat (baud / 2) @(negedge lclk);
            for (int b = 0; b < 8; b++) begin
                repeat (baud) @(negedge lclk);
                c[b] = slow ? tx_s : tx_f;
            end
            repeat (baud) @(negedge lclk);
            ok = ((slow ? tx_s : tx_f) === 1'b1);
        end
    endtask

    task automatic get_line(input bit slow, output logic [31:0] w, output bit ok);
        logic [7:0] c;
        bit         okc;
        w = 32'h0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get_char(slow, c, okc);
            w = {w[23:0], c};
            ok = ok & okc;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (tx_f !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx got %b exp 1", tx_f); end
        tests_run++; if (cnt_f !== 5'd0)  begin tests_failed++; $display("FAIL reset_count got %0d exp 0", cnt_f); end
        tests_run++; if (ovf_f !== 1'b0)  begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", ovf_f); end
        tests_run++; if (busy_f !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy_f); end
        tests_run++; if ({tx_s, cnt_s, ovf_s, busy_s} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL reset_slow got tx=%b cnt=%0d ovf=%b busy=%b", tx_s, cnt_s, ovf_s, busy_s);
        end
    endtask

    // Default baud: exact start latency, line length and busy release.
    task automatic test_single_line();
        int t_pre, n, fall_idx, busy_idx;
        logic [7:0] exp_c [4];
        logic [7:0] c;
        bit ok;
        exp_c[0] = 8'h41; exp_c[1] = 8'h35; exp_c[2] = 8'h0D; exp_c[3] = 8'h0A;
        apply_reset();
        post_wr = 1'b1; post_data = 8'hA5; t_pre = cyc;
        @(negedge lclk);
        post_wr = 1'b0;
        n = 0;
        while ((tx_s !== 1'b0) && (n < 20)) begin @(negedge lclk); n++; end
        fall_idx = cyc - t_pre - 1;
        tests_run++; if (fall_idx != 3) begin tests_failed++; $display("FAIL single_start_latency got %0d exp 3", fall_idx); end
        for (int i = 0; i < 4; i++) begin
            get_char(1'b1, c, ok);
            tests_run++; if ((c !== exp_c[i]) || !ok) begin
                tests_failed++; $display("FAIL single_char%0d got %h ok=%0d exp %h", i, c, ok, exp_c[i]);
            end
        end
        n = 0;
        while ((busy_s !== 1'b0) && (n < 2 * SLOW_BAUD)) begin @(negedge lclk); n++; end
        busy_idx = cyc - t_pre - 1;
        tests_run++; if (busy_idx - fall_idx != 40 * SLOW_BAUD) begin
            tests_failed++; $display("FAIL single_line_time got %0d exp %0d", busy_idx - fall_idx, 40 * SLOW_BAUD);
        end
        tests_run++; if (busy_idx != 3 + 40 * SLOW_BAUD) begin
            tests_failed++; $display("FAIL single_busy_fall got %0d exp %0d", busy_idx, 3 + 40 * SLOW_BAUD);
        end
        tests_run++; if ({tx_s, cnt_s} !== {1'b1, 5'd0}) begin
            tests_failed++; $display("FAIL single_idle_after got tx=%b cnt=%0d exp tx=1 cnt=0", tx_s, cnt_s);
        end
    endtask

    task automatic test_burst_overflow();
        logic [31:0] lines [17];
        bit          oks [17];
        int          peak, n;
        apply_reset();
        peak = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    post_wr = 1'b1; post_data = 8'(i);
                    @(negedge lclk);
                    if (int'(cnt_f) > peak) peak = int'(cnt_f);
                end
                post_wr = 1'b0;
            end
            begin
                for (int l = 0; l < 17; l++) get_line(1'b0, lines[l], oks[l]);
            end
        join
        tests_run++; if (peak != 16) begin tests_failed++; $display("FAIL burst_peak got %0d exp 16", peak); end
        tests_run++; if (ovf_f !== 1'b1) begin tests_failed++; $display("FAIL burst_overflow got %b exp 1", ovf_f); end
        for (int l = 0; l < 17; l++) begin
            tests_run++; if ((lines[l] !== exp_line(8'(l))) || !oks[l]) begin
                tests_failed++; $display("FAIL burst_line%0d got %h ok=%0d exp %h", l, lines[l], oks[l], exp_line(8'(l)));
            end
        end
        n = 0;
        while ((tx_f === 1'b1) && (n < 200)) begin @(negedge lclk); n++; end
        tests_run++; if ({tx_f, busy_f, cnt_f} !== {1'b1, 1'b0, 5'd0}) begin
            tests_failed++; $display("FAIL burst_stops got tx=%b busy=%b cnt=%0d exp 1 0 0", tx_f, busy_f, cnt_f);
        end
    endtask

    // Line 0x20 ends at edge 162; IDLE->POP at 163; the pop edge 164 gets the 0x7E strobe.
    task automatic test_full_pop_push();
        logic [31:0] lines [18];
        bit          oks [18];
        int          t_pre;
        apply_reset();
        t_pre = cyc;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    post_wr = 1'b1; post_data = 8'h20 + 8'(i);
                    @(negedge lclk);
                end
                post_wr = 1'b0;
                while (cyc - t_pre - 1 < 163) @(negedge lclk);
                tests_run++; if (cnt_f !== 5'd16) begin tests_failed++; $display("FAIL fullpop_pre_count got %0d exp 16", cnt_f); end
                post_wr = 1'b1; post_data = 8'h7E;
                @(negedge lclk);
                post_wr = 1'b0;
                tests_run++; if (cnt_f !== 5'd16) begin tests_failed++; $display("FAIL fullpop_count got %0d exp 16", cnt_f); end
                tests_run++; if (ovf_f !== 1'b0)  begin tests_failed++; $display("FAIL fullpop_overflow got %b exp 0", ovf_f); end
            end
            begin
                for (int l = 0; l < 18; l++) get_line(1'b0, lines[l], oks[l]);
            end
        join
        for (int l = 0; l < 18; l++) begin
            logic [7:0] v;
            v = (l == 17) ? 8'h7E : 8'h20 + 8'(l);
            tests_run++; if ((lines[l] !== exp_line(v)) || !oks[l]) begin
                tests_failed++; $display("FAIL fullpop_line%0d got %h ok=%0d exp %h", l, lines[l], oks[l], exp_line(v));
            end
        end
    endtask

    // 'F' (0x46) of code 0x3F starts at edge 43; at edge 63 data bit 4 (0) is on the line.
    task automatic test_reset_midframe();
        int t_pre;
        logic [31:0] w;
        bit ok;
        apply_reset();
        t_pre = cyc;
        for (int i = 0; i < 18; i++) begin
            post_wr = 1'b1; post_data = (i == 0) ? 8'h3F : 8'(i - 1);
            @(negedge lclk);
        end
        post_wr = 1'b0;
        while (cyc - t_pre - 1 < 63) @(negedge lclk);
        tests_run++; if ({tx_f, ovf_f, cnt_f} !== {1'b0, 1'b1, 5'd16}) begin
            tests_failed++; $display("FAIL midframe_pre got tx=%b ovf=%b cnt=%0d exp 0 1 16", tx_f, ovf_f, cnt_f);
        end
        lreset_n = 1'b0;
        #1;
        tests_run++; if ({tx_f, tx_s} !== 2'b11) begin tests_failed++; $display("FAIL midframe_tx_high got %b%b exp 11", tx_f, tx_s); end
        repeat (2) @(negedge lclk);
        lreset_n = 1'b1;
        @(negedge lclk);
        tests_run++; if ({cnt_f, ovf_f, busy_f} !== {5'd0, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL midframe_after got cnt=%0d ovf=%b busy=%b exp 0 0 0", cnt_f, ovf_f, busy_f);
        end
        post_wr = 1'b1; post_data = 8'h01;
        @(negedge lclk);
        post_wr = 1'b0;
        get_line(1'b0, w, ok);
        tests_run++; if ((w !== 32'h30310D0A) || !ok) begin tests_failed++; $display("FAIL midframe_clean_line got %h ok=%0d exp 30310d0a", w, ok); end
    endtask

    task automatic test_nibbles_wrap();
        logic [7:0]  codes [4];
        logic [31:0] lines [10];
        bit          oks [10];
        codes[0] = 8'h09; codes[1] = 8'h0A; codes[2] = 8'hF0; codes[3] = 8'hFF;
        apply_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) begin post_wr = 1'b1; post_data = codes[i]; @(negedge lclk); end
                post_wr = 1'b0;
            end
            begin
                for (int l = 0; l < 4; l++) get_line(1'b0, lines[l], oks[l]);
            end
        join
        for (int l = 0; l < 4; l++) begin
            tests_run++; if ((lines[l] !== exp_line(codes[l])) || !oks[l]) begin
                tests_failed++; $display("FAIL nibble_line%0d got %h exp %h", l, lines[l], exp_line(codes[l]));
            end
        end
        for (int b = 0; b < 4; b++) begin
            fork
                begin
                    for (int i = 0; i < 10; i++) begin post_wr = 1'b1; post_data = 8'h80 + 8'(b * 10 + i); @(negedge lclk); end
                    post_wr = 1'b0;
                end
                begin
                    for (int l = 0; l < 10; l++) get_line(1'b0, lines[l], oks[l]);
                end
            join
            for (int l = 0; l < 10; l++) begin
                tests_run++; if ((lines[l] !== exp_line(8'h80 + 8'(b * 10 + l))) || !oks[l]) begin
                    tests_failed++; $display("FAIL wrap_line%0d got %h exp %h", b * 10 + l, lines[l], exp_line(8'h80 + 8'(b * 10 + l)));
                end
            end
        end
        tests_run++; if (ovf_f !== 1'b0) begin tests_failed++; $display("FAIL wrap_overflow got %b exp 0", ovf_f); end
    endtask

    task automatic test_dedup();
        logic [7:0]  codes [4];
        logic [7:0]  expv [4];
        logic [31:0] lines [4];
        bit          oks [4];
        int          n_exp, n;
        codes[0] = 8'h55; codes[1] = 8'h55; codes[2] = 8'h56; codes[3] = 8'h55;
`ifdef POST_DEDUP_EN
        n_exp = 3; expv[0] = 8'h55; expv[1] = 8'h56; expv[2] = 8'h55; expv[3] = 8'h00;
`else
        n_exp = 4; expv[0] = 8'h55; expv[1] = 8'h55; expv[2] = 8'h56; expv[3] = 8'h55;
`endif
        apply_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) begin post_wr = 1'b1; post_data = codes[i]; @(negedge lclk); end
                post_wr = 1'b0;
            end
            begin
                for (int l = 0; l < n_exp; l++) get_line(1'b0, lines[l], oks[l]);
            end
        join
        for (int l = 0; l < n_exp; l++) begin
            tests_run++; if ((lines[l] !== exp_line(expv[l])) || !oks[l]) begin
                tests_failed++; $display("FAIL dedup_line%0d got %h exp %h", l, lines[l], exp_line(expv[l]));
            end
        end
        n = 0;
        while ((tx_f === 1'b1) && (n < 200)) begin @(negedge lclk); n++; end
        tests_run++; if ({tx_f, ovf_f, cnt_f} !== {1'b1, 1'b0, 5'd0}) begin
            tests_failed++; $display("FAIL dedup_no_extra got tx=%b ovf=%b cnt=%0d exp 1 0 0", tx_f, ovf_f, cnt_f);
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_burst_overflow();
        test_full_pop_push();
        test_reset_midframe();
        test_nibbles_wrap();
        test_dedup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/post_code_logger.md
Name: post_code_logger

Overview:
- Downstream consumer of the port-0x80 POST-code capture path.
- Every host I/O write that hits the POST-code decode is captured into a small FIFO.
- Captured codes are replayed on a dedicated debug UART TX pin as hex ASCII lines, e.g. "A5\r\n".
- Gives a full boot-progress history, not just the last code shown on the 7-segment/LED outputs.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries (16).
- BAUD_DIV, 286: lclk cycles per UART bit (33 MHz / 115200, truncated).

Ports:
- lclk  input  1  LPC clock, 33 MHz; all logic on rising edge.
- lreset_n  input  1  asynchronous active-low reset.
- post_wr  input  1  one-cycle strobe: I/O write to POST address (io_wren & device_cs).
- post_data  input  8  write data, valid when post_wr=1.
- tx  output  1  UART TX, 8N1, LSB first, idle high.
- fifo_count  output  DEPTH_LOG2+1  entries currently queued.
- overflow  output  1  sticky: a code was dropped because the FIFO was full.
- busy  output  1  high while the FIFO is non-empty or a line is being sent.

Behaviour:
- Reset (async assert, sync-to-lclk deassert not required internally):
  - tx=1, fifo_count=0, overflow=0, busy=0.
  - FSM=IDLE, read/write pointers=0, bit counter and baud counter=0.
  - Reset mid-frame aborts the frame immediately; tx returns high in the same cycle reset asserts.
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH.
  - Push: on post_wr=1, accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Full case: otherwise the code is dropped and overflow is set to 1; overflow clears only on reset.
  - Push and pop in the same cycle leave count unchanged.
  - Empty: no pop issued.
- Sender FSM states: IDLE, POP, HI, LO, CR, LF.
  - IDLE: if count>0, go to POP (1 cycle).
  - POP: latch head entry into the code register, advance the read pointer, decrement count.
  - HI: send the upper nibble as a character.
  - LO: send the lower nibble as a character.
  - CR: send 0x0D.
  - LF: send 0x0A, then return to IDLE.
  - Nibble to ASCII: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
- Character framing:
  - 10 bits: start(0), d0..d7, stop(1).
  - Each bit is held exactly BAUD_DIV cycles, so one character = 10*BAUD_DIV cycles.
  - The next character's start bit begins the cycle after the previous stop bit ends; no extra idle.
- Latency:
  - Pop occurs 1 cycle after the FSM sees count>0 in IDLE.
  - The start bit of HI appears on tx 1 cycle after POP.
  - From post_wr on an empty/idle logger to the tx falling edge: 3 cycles.
- busy = (count!=0) | (FSM!=IDLE).
- Writes arriving while a line is in transmission are only queued; they never disturb the current line.

Optional Feature:
- Macro: POST_DEDUP_EN.
- Defined:
  - A push whose post_data equals the last accepted code since reset is discarded.
  - A discarded duplicate does not change count and does not set overflow.
  - The "last accepted" register resets to 0x00 with a valid flag of 0, so the first code is always accepted.
- Undefined: every post_wr is queued, subject to the full rule.

Test Plan:
- Reset, then single post_wr with data 0xA5 -> tx sends 0x41,0x35,0x0D,0x0A. Check:
  - Start bit at cycle 3 after the strobe.
  - Total line time 40*286 cycles.
  - busy falls 1 cycle after the LF stop bit.
- 20 back-to-back strobes, data 0x00..0x13, while idle:
  - 1 pops immediately; 16 are queued; 3 are dropped.
  - overflow=1; fifo_count peaks at 16.
  - tx emits lines "00".."10" in order, then stops.
- Full FIFO with a pop coinciding with post_wr=0x7E -> code accepted, fifo_count stays 16, overflow unchanged.
- Assert lreset_n=0 in the middle of the "F" character of code 0x3F:
  - tx=1 immediately.
  - After release: fifo_count=0, overflow=0.
  - Next strobe 0x01 produces a clean "01\r\n".
- Nibble boundary values 0x09, 0x0A, 0xF0, 0xFF -> ASCII "09","0A","F0","FF"; pointer wrap exercised with 40 sequential codes.
- With POST_DEDUP_EN: strobes 0x55,0x55,0x56,0x55 -> 3 lines "55","56","55", overflow=0. Without it: 4 lines.
